// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive path: default FIFO geometry, line rate
// defaults, and the push/pop operation encoding used by the FIFO control logic.
package uart_rx_fifo_pkg;

    localparam int unsigned UART_FIFO_DEPTH  = 8;
    localparam int unsigned UART_DATA_WIDTH  = 8;
    localparam int unsigned UART_CLK_FREQ_HZ = 50_000_000;
    localparam int unsigned UART_BAUD        = 115_200;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO: one synchronous write port and one
// asynchronous (show-ahead) read port. Contents are deliberately not reset.
module fifo_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO sitting directly behind the UART receiver: show-ahead output,
// registered occupancy flags and a sticky overrun flag for dropped bytes.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned WIDTH = UART_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overrun,
    input  logic                     clr_overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             push_s, pop_s, drop_s;
    fifo_op_e         op_s;
    logic [WIDTH-1:0] rd_data_s;

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign pop_s  = valid_q & out_ready;
    assign push_s = in_valid & (~full_q | pop_s);
    assign drop_s = in_valid & full_q & ~pop_s;
    assign op_s   = fifo_op_e'({push_s, pop_s});

    // Next-state for pointers, occupancy and flags
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        case (op_s)
            OP_PUSH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                count_d  = count_q + CW'(1);
            end
            OP_POP: begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - CW'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            default: begin
                count_d = count_q;
            end
        endcase
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        full_d  = (count_d == DEPTH_C);
        valid_d = (count_d != ZERO_C);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= ZERO_C;
            full_q    <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

    // Stale memory is masked so the output reads zero whenever nothing is held.
    assign out_data  = valid_q ? rd_data_s : {WIDTH{1'b0}};
    assign out_valid = valid_q;
    assign count     = count_q;
    assign full      = full_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of byte entries; power of two, 2..256.
REQ-002 Parameter WIDTH, default 8, data bits per entry.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  received byte from the UART receiver.
REQ-006 in_valid  input  1  one-cycle strobe; in_data is valid in that cycle.
REQ-007 out_data  output  WIDTH  head entry, show-ahead, valid while out_valid=1.
REQ-008 out_valid  output  1  FIFO holds at least one entry.
REQ-009 out_ready  input  1  consumer pops the head when out_valid=1 and out_ready=1.
REQ-010 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 full  output  1  count==DEPTH.
REQ-012 overrun  output  1  sticky flag; a byte was dropped.
REQ-013 clr_overrun  input  1  synchronous clear of overrun.

Function
REQ-014 The block SHALL accept a push when in_valid=1 and (full=0, or full=1 with a pop in the same cycle).
REQ-015 The block SHALL drop in_data, leave contents unchanged, and set overrun on the next edge when in_valid=1, full=1 and no pop occurs.
REQ-016 A pop SHALL occur only when out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-017 The first push into an empty FIFO SHALL appear on out_data with out_valid=1 one cycle after the in_valid strobe.
REQ-018 After a pop, out_data SHALL present the next entry in the following cycle with no bubble when count>1.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-020 Simultaneous push and pop on an empty FIFO SHALL NOT occur, since a pop needs out_valid=1; the push SHALL be accepted normally.
REQ-021 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0 without extra logic.
REQ-022 count SHALL increment on push-only, decrement on pop-only, and otherwise hold; it SHALL never exceed DEPTH or go below 0.
REQ-023 full and out_valid SHALL be registered, or decoded from count, with no combinational path from in_valid or out_ready.
REQ-024 overrun SHALL stay set until clr_overrun=1; if a clear and a new drop occur in the same cycle, set SHALL win.
REQ-025 Data order SHALL be strict first-in first-out; no entry SHALL be duplicated or lost except by REQ-015.

Reset
REQ-026 Asserting rst SHALL immediately force pointers=0, count=0, out_valid=0, full=0 and overrun=0.
REQ-027 out_data SHALL be all-zeros during reset; memory contents need not be cleared.
REQ-028 A reset asserted mid-operation SHALL discard all stored bytes; a push in the cycle rst deasserts SHALL be accepted.

Structure
REQ-029 Shared constants (default DEPTH, WIDTH, UART F/BAUD defaults) SHALL live in the common UART include file used by the receiver.
REQ-030 Storage SHALL be a single sub-module fifo_mem: DEPTH x WIDTH, one synchronous write port and one asynchronous read port; pointer and flag logic SHALL stay in uart_rx_fifo.
REQ-031 The block SHALL connect directly to the receiver's byte output and done strobe, with no glue logic.

Verification
REQ-032 After reset, push 0x41 -> one cycle later out_valid=1, out_data=0x41, count=1.
REQ-033 Push 0x01..0x08 (DEPTH=8) with out_ready=0 -> full=1, count=8; push 0x09 -> overrun=1, count=8; pop all -> 0x01..0x08 in order, empty.
REQ-034 FIFO full, push 0xAA and pop in the same cycle -> overrun stays 0, count=8, and 0xAA is read last.
REQ-035 Pushes and pops continuous for 20 bytes with out_ready=1 -> bytes are read in order and pointers wrap twice.
REQ-036 Assert rst asynchronously between edges with count=5 -> out_valid and count drop at once; the next push is read back correctly.
REQ-037 overrun=1, clr_overrun=1 in the same cycle as a dropped push -> overrun stays 1; clr_overrun alone the next cycle -> 0.
